// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader: FSM encodings and frame constants.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    LD_LEN,
    LD_DATA,
    LD_RUN,
    LD_ERR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver on an already-synchronised line; samples mid-bit after a validated start.
module uart_rx_byte
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       frame_start
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [7:0]       shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      frame_err   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
      frame_start <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (rx) begin
              state <= RX_IDLE;
            end else begin
              state       <= RX_DATA;
              frame_start <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shift   <= {rx, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: length byte then that many program bytes written from address 0, then releases the core.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              run,
  output logic              busy,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic          rx_meta, rx_sync;
  logic          byte_valid, frame_err, frame_start;
  logic [7:0]    byte_data;
  loader_state_t state;
  logic [7:0]    remaining;
  logic [ADDR_W:0] addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx_sync),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err),
    .frame_start(frame_start)
  );

  // The final write moves to RUN; run/busy update one cycle later so run follows the last mem_we.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LD_LEN;
      remaining <= '0;
      addr      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      run       <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        LD_LEN: begin
          if (frame_err) begin
            state <= LD_ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else if (byte_valid) begin
            if (byte_data == 8'd0) begin
              state <= LD_RUN;
              run   <= 1'b1;
              busy  <= 1'b0;
            end else if (32'(byte_data) > DEPTH) begin
              state <= LD_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= LD_DATA;
              remaining <= byte_data;
              addr      <= '0;
            end
          end else if (frame_start) begin
            busy <= 1'b1;
          end
        end
        LD_DATA: begin
          if (frame_err) begin
            state <= LD_ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else if (byte_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr[ADDR_W-1:0];
            mem_wdata <= byte_data;
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == 8'd1) state <= LD_RUN;
          end else if (frame_start) begin
            busy <= 1'b1;
          end
        end
        LD_RUN: begin
          run  <= 1'b1;
          busy <= 1'b0;
        end
        LD_ERR: begin
          err  <= 1'b1;
          busy <= 1'b0;
        end
        default: state <= LD_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised and directed checks of prog_loader against a stream-level reference model.
module tb_prog_loader;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          run, busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .run      (run),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Observed write log and event times, collected away from the active edge
  int wr_addr_q[$];
  int wr_data_q[$];
  int cyc = 0;
  int last_we_cyc, run_rise_cyc, busy_fall_cyc;
  bit saw_busy, prev_run, prev_busy;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      wr_addr_q.delete();
      wr_data_q.delete();
      last_we_cyc   = -1;
      run_rise_cyc  = -1;
      busy_fall_cyc = -1;
      saw_busy  = 1'b0;
      prev_run  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (mem_we) begin
        wr_addr_q.push_back(int'(mem_addr));
        wr_data_q.push_back(int'(mem_wdata));
        last_we_cyc = cyc;
      end
      if (run && !prev_run) run_rise_cyc = cyc;
      if (!busy && prev_busy) busy_fall_cyc = cyc;
      if (busy) saw_busy = 1'b1;
      prev_run  = run;
      prev_busy = busy;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus stream: bytes plus a per-byte good-stop flag
  logic [7:0] stream[$];
  bit         stop_ok[$];

  task automatic add_byte(input logic [7:0] b, input bit ok);
    stream.push_back(b);
    stop_ok.push_back(ok);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(ok);
  endtask

  task automatic do_reset();
    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we",    int'(mem_we), 0);
    check("rst_addr",  int'(mem_addr), 0);
    check("rst_wdata", int'(mem_wdata), 0);
    check("rst_run",   int'(run), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_err",   int'(err), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reference model: interpret the stream as length + payload
  int  exp_addr_q[$];
  int  exp_data_q[$];
  bit  exp_run, exp_err;
  int  exp_len;

  task automatic build_model();
    int n;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_run = 1'b0;
    exp_err = 1'b0;
    exp_len = -1;
    n = 0;
    for (int i = 0; i < stream.size(); i++) begin
      if (exp_run || exp_err) break;
      if (!stop_ok[i]) begin
        exp_err = 1'b1;
      end else if (exp_len < 0) begin
        exp_len = int'(stream[i]);
        if (exp_len == 0) exp_run = 1'b1;
        else if (exp_len > int'(DEPTH)) exp_err = 1'b1;
      end else begin
        exp_addr_q.push_back(n);
        exp_data_q.push_back(int'(stream[i]));
        n++;
        if (n == exp_len) exp_run = 1'b1;
      end
    end
  endtask

  task automatic run_case(input string name);
    int nw;
    do_reset();
    build_model();
    for (int i = 0; i < stream.size(); i++) send_byte(stream[i], stop_ok[i]);
    rx = 1'b1;
    repeat (14 * CPB + 10) @(posedge clk);
    #1;
    check({name, "_nwr"},  wr_addr_q.size(), exp_addr_q.size());
    nw = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < nw; i++) begin
      check({name, "_waddr"}, wr_addr_q[i], exp_addr_q[i]);
      check({name, "_wdata"}, wr_data_q[i], exp_data_q[i]);
    end
    check({name, "_run"},  int'(run), int'(exp_run));
    check({name, "_err"},  int'(err), int'(exp_err));
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_sawbusy"}, int'(saw_busy), int'(stream.size() > 0));
    if (exp_run && exp_len > 0)
      check({name, "_run_lat"}, run_rise_cyc - last_we_cyc, 1);
    if (exp_run)
      check({name, "_busy_fall"}, busy_fall_cyc, run_rise_cyc);
    stream.delete();
    stop_ok.delete();
  endtask

  initial begin
    int len, extra, bad_pos;

    // Idle line after reset
    do_reset();
    repeat (100) @(posedge clk);
    #1;
    check("idle_nwr",  wr_addr_q.size(), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_sawbusy", int'(saw_busy), 0);

    // Normal load
    add_byte(8'h03, 1); add_byte(8'hA5, 1); add_byte(8'h3C, 1); add_byte(8'hFF, 1);
    run_case("normal");

    add_byte(8'h00, 1);
    run_case("len0");

    add_byte(8'h10, 1);
    for (int i = 0; i < 16; i++) add_byte(8'($urandom), 1);
    run_case("full");

    add_byte(8'h11, 1); add_byte(8'h55, 1);
    run_case("oversize");

    add_byte(8'h02, 1); add_byte(8'h11, 1); add_byte(8'h5A, 0);
    run_case("framing");

    // Traffic after run, including a bad frame, must be ignored
    add_byte(8'h01, 1); add_byte(8'h42, 1); add_byte(8'h99, 1); add_byte(8'h33, 0);
    run_case("after_run");

    // One-cycle glitch is a false start
    do_reset();
    rx = 1'b0;
    @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("glitch_nwr", wr_addr_q.size(), 0);
    check("glitch_sawbusy", int'(saw_busy), 0);
    check("glitch_run", int'(run), 0);
    check("glitch_err", int'(err), 0);

    // Reset in the middle of the second data byte, then a fresh load
    do_reset();
    send_byte(8'h04, 1);
    send_byte(8'h11, 1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    check("midrst_pre_nwr", wr_addr_q.size(), 1);
    add_byte(8'h01, 1); add_byte(8'h7E, 1);
    run_case("midrst");

    // Randomised loads
    for (int t = 0; t < 10; t++) begin
      len = int'($urandom_range(0, 18));
      extra = int'($urandom_range(0, 2));
      add_byte(8'(len), 1);
      if (len <= int'(DEPTH)) begin
        for (int i = 0; i < len + extra; i++) add_byte(8'($urandom), 1);
      end else begin
        add_byte(8'($urandom), 1);
      end
      if ($urandom_range(0, 3) == 0) begin
        bad_pos = int'($urandom_range(0, stream.size() - 1));
        stop_ok[bad_pos] = 1'b0;
      end
      run_case($sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
